pixel_writer: RTL

- Write-side companion to the VGA pixel reader: accepts draw requests (cell x, y, colour code) from the game datapath and writes them into video memory port 2, which the bit generator reads during active video.
- Owns port 2 only while `bright` is low (blanking), so display reads are never disturbed.
- Cells are packed four per 16-bit word, so every draw is a read-modify-write; a full-screen clear command is also provided.

---
 rtl/pixel_writer_pkg.sv | 35 +++
 rtl/pixel_writer_sync_fifo.sv | 56 +++++
 rtl/pixel_writer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pixel_writer_pkg.sv
// Shared definitions for the framebuffer writer and the bit generator: grid defaults,
// writer FSM encoding and the cell -> (word address, nibble) mapping.
package pixel_writer_pkg;

  localparam int unsigned DefGridW    = 160;
  localparam int unsigned DefGridH    = 120;
  localparam logic [15:0] DefBaseAddr = 16'h2000;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StMerge,
    StWrite,
    StClear
  } state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  nib;
  } cell_loc_t;

  // Four 4-bit cells per 16-bit word, row-major from the base address.
  function automatic cell_loc_t cell_loc(input logic [7:0]  x,
                                         input logic [6:0]  y,
                                         input int unsigned grid_w,
                                         input logic [15:0] base);
    logic [14:0] idx;
    cell_loc_t   loc;
    idx      = 15'(32'(y) * grid_w + 32'(x));
    loc.addr = base + {3'b000, idx[14:2]};
    loc.nib  = idx[1:0];
    return loc;
  endfunction

endpackage

// File: rtl/pixel_writer_sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides; ready is registered from occupancy.
module pixel_writer_sync_fifo #(
  parameter int unsigned Width = 19,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             ready_q;
  logic             push, pop;

  assign push        = in_valid_i && ready_q;
  assign pop         = out_ready_i && (count_q != '0);
  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_q];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Pointers, count and registered ready; a pop on a full FIFO frees a slot next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wr_q <= wr_q + PtrW'(1);
      if (pop)  rd_q <= rd_q + PtrW'(1);
      count_q <= count_d;
      ready_q <= (count_d != CntW'(Depth));
    end
  end

  // Entry storage; needs no reset since out_valid_o gates its use.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= in_data_i;
  end

endmodule

// File: rtl/pixel_writer.sv
// Framebuffer writer: queues draw requests and performs read-modify-write of packed cells
// on video memory port 2, only during blanking. Also provides a full-screen clear.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int unsigned GRID_W     = DefGridW,
  parameter int unsigned GRID_H     = DefGridH,
  parameter logic [15:0] BASE_ADDR  = DefBaseAddr,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bright,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_x,
  input  logic [6:0]  req_y,
  input  logic [3:0]  req_color,
  input  logic        clr_start,
  output logic        mem_own,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        coord_err
);

  localparam int unsigned EntryW   = 19;
  localparam int unsigned ClrWords = GRID_W * GRID_H / 4;
  localparam int unsigned ClrW     = $clog2(ClrWords);

  state_e            state_q;
  logic [15:0]       addr_q, wdata_q;
  logic [1:0]        nib_q;
  logic [3:0]        color_q;
  logic [ClrW-1:0]   clr_cnt_q;
  logic              clr_pend_q, coord_err_q;

  logic              in_range, accept;
  logic              fifo_out_valid, fifo_pop;
  logic [EntryW-1:0] fifo_out_data;
  cell_loc_t         head_loc;
  logic [15:0]       merge_word;

  assign in_range = (32'(req_x) < GRID_W) && (32'(req_y) < GRID_H);
  assign accept   = req_valid && req_ready;
  assign fifo_pop = (state_q == StWrite) && !bright;

  pixel_writer_sync_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .in_valid_i  (req_valid && in_range),
    .in_ready_o  (req_ready),
    .in_data_i   ({req_x, req_y, req_color}),
    .out_valid_o (fifo_out_valid),
    .out_ready_i (fifo_pop),
    .out_data_o  (fifo_out_data)
  );

  assign head_loc = cell_loc(fifo_out_data[18:11], fifo_out_data[10:4], GRID_W, BASE_ADDR);

  // Replace the addressed nibble of the word read back from memory.
  always_comb begin
    merge_word = mem_rdata;
    merge_word[{nib_q, 2'b00} +: 4] = color_q;
  end

  // Writer FSM; any loss of blanking mid-RMW restarts at READ so stale data is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      nib_q       <= '0;
      color_q     <= '0;
      clr_cnt_q   <= '0;
      clr_pend_q  <= 1'b0;
      coord_err_q <= 1'b0;
    end else begin
      if (accept && !in_range) coord_err_q <= 1'b1;
      if (clr_start)           clr_pend_q  <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (clr_pend_q) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
          end else if (fifo_out_valid) begin
            state_q <= StRead;
            addr_q  <= head_loc.addr;
            nib_q   <= head_loc.nib;
            color_q <= fifo_out_data[3:0];
          end
        end
        StRead: begin
          if (!bright) state_q <= StMerge;
        end
        StMerge: begin
          if (!bright) begin
            wdata_q <= merge_word;
            state_q <= StWrite;
          end else begin
            state_q <= StRead;
          end
        end
        StWrite: begin
          state_q <= bright ? StRead : StIdle;
        end
        StClear: begin
          if (clr_start) begin
            clr_cnt_q <= '0;
            addr_q    <= BASE_ADDR;
          end else if (!bright) begin
            if (clr_cnt_q == ClrW'(ClrWords - 1)) begin
              state_q    <= StIdle;
              clr_pend_q <= 1'b0;
            end else begin
              clr_cnt_q <= clr_cnt_q + ClrW'(1);
              addr_q    <= addr_q + 16'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bus ownership follows the registered state but drops the same cycle bright rises.
  assign mem_own   = (state_q != StIdle) && !bright;
  assign mem_we    = ((state_q == StWrite) || (state_q == StClear)) && !bright;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = fifo_out_valid || (state_q != StIdle) || clr_pend_q;
  assign coord_err = coord_err_q;

endmodule
